// File: rtl/npc_mem_pkg.sv
// Shared types and defaults for the NPC memory-port arbiter.
package npc_mem_pkg;

  localparam int DEF_ADDR_W = 64;
  localparam int DEF_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant; on a tie the requester not served last wins.
module rr_arb2
  import npc_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_if,
  input  logic req_ls,
  input  logic update,
  output logic gnt_if,
  output logic gnt_ls
);

  owner_t last_grant;

  always_comb begin
    gnt_if = 1'b0;
    gnt_ls = 1'b0;
    if (req_if && req_ls) begin
      gnt_if = (last_grant == OWN_LS);
      gnt_ls = (last_grant == OWN_IF);
    end else begin
      gnt_if = req_if;
      gnt_ls = req_ls;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= OWN_LS;
    end else if (update) begin
      last_grant <= gnt_ls ? OWN_LS : OWN_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one
// transaction in flight, with a response timeout and sticky bus_err.
//
// state | meaning
// IDLE  | grant one upstream request and latch it
// REQ   | present the buffered request downstream until accepted
// WAIT  | await the memory response or the timeout
module mem_port_arbiter
  import npc_mem_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_data,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic                ls_req_wen,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_resp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic                bus_err
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(RESP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(RESP_TIMEOUT);

  arb_state_t          state, state_d;
  logic [CNT_W-1:0]    cnt;
  owner_t              owner;
  logic [ADDR_W-1:0]   buf_addr;
  logic                buf_wen;
  logic [DATA_W-1:0]   buf_wdata;
  logic [MASK_W-1:0]   buf_wmask;
  logic                gnt_if, gnt_ls;
  logic                accept;
  logic                resp_fire, timeout;
  logic                resp_pulse;
  logic [DATA_W-1:0]   resp_data;

  // Reset gates the handshakes so nothing is accepted or delivered while it is held.
  assign accept = (state == IDLE) && !rst && (gnt_if || gnt_ls);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_if (if_req_valid),
    .req_ls (ls_req_valid),
    .update (accept),
    .gnt_if (gnt_if),
    .gnt_ls (gnt_ls)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    resp_fire = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_d = REQ;
      end
      REQ: begin
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        // A response on the timeout cycle wins over the abort.
        if (mem_resp_valid) begin
          resp_fire = 1'b1;
          state_d   = IDLE;
        end else if (cnt == TO_CNT) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      owner     <= OWN_IF;
      buf_addr  <= '0;
      buf_wen   <= 1'b0;
      buf_wdata <= '0;
      buf_wmask <= '0;
      bus_err   <= 1'b0;
    end else begin
      if (accept) begin
        owner     <= gnt_ls ? OWN_LS : OWN_IF;
        buf_addr  <= gnt_ls ? ls_req_addr : if_req_addr;
        buf_wen   <= gnt_ls && ls_req_wen;
        buf_wdata <= gnt_ls ? ls_req_wdata : '0;
        buf_wmask <= gnt_ls ? ls_req_wmask : '0;
      end
      if (state == REQ) begin
        cnt <= '0;
      end else if (state == WAIT && state_d == WAIT) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (timeout) bus_err <= 1'b1;
    end
  end

  assign if_req_ready  = accept && gnt_if;
  assign ls_req_ready  = accept && gnt_ls;

  assign mem_req_valid = (state == REQ) && !rst;
  assign mem_req_addr  = buf_addr;
  assign mem_req_wen   = buf_wen;
  assign mem_req_wdata = buf_wdata;
  assign mem_req_wmask = buf_wmask;

  assign resp_pulse    = (resp_fire || timeout) && !rst;
  assign resp_data     = resp_fire ? mem_resp_data : '0;

  assign if_resp_valid = resp_pulse && (owner == OWN_IF);
  assign ls_resp_valid = resp_pulse && (owner == OWN_LS);
  assign if_resp_data  = if_resp_valid ? resp_data : '0;
  assign ls_resp_data  = ls_resp_valid ? resp_data : '0;

endmodule
